// File: rtl/posit_defines_es3.sv
// Shared posit<32,3> constants and record types for the ES3 datapaths.
// Also holds the decoder's intermediate stage records.
package posit_defines_es3;

  localparam int NBITS = 32;
  localparam int ES = 3;
  localparam int FBITS = NBITS - ES - 3;
  localparam int SCALE_W = 9;
  localparam int POSIT_SERIALIZED_WIDTH_ES3 = 1 + SCALE_W + FBITS + 2;
  localparam int REGIME_W = 6;
  localparam int ABS_W = NBITS - 1;
  localparam int RUN_W = 5;
  localparam int SHAMT_W = 6;

  localparam logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] VALUE_ZERO = 38'h1;
  localparam logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] VALUE_INF  = 38'h2;
  localparam logic [NBITS-1:0] POSIT_NAR = 32'h8000_0000;

  typedef struct packed {
    logic               sgn;
    logic [SCALE_W-1:0] scale;
    logic [FBITS-1:0]   fraction;
    logic               inf;
    logic               zero;
  } posit_value_es3_t;

  typedef struct packed {
    logic             sgn;
    logic [ABS_W-1:0] abs_val;
    logic             inf;
    logic             zero;
  } posit_stage1_es3_t;

  typedef struct packed {
    logic                       sgn;
    logic signed [REGIME_W-1:0] regime;
    logic [ABS_W-1:0]           rem;
    logic                       inf;
    logic                       zero;
  } posit_stage2_es3_t;

endpackage

// File: rtl/posit_run_count_es3.sv
// Leading-run counter: length of the run of bits equal to polarity, from the MSB down.
// Built as a leading-zero count of bits ^ polarity; an all-equal word yields 31.
module posit_run_count_es3
  import posit_defines_es3::*;
(
  input  logic [ABS_W-1:0] bits,
  input  logic             polarity,
  output logic [RUN_W-1:0] count
);

  logic [ABS_W-1:0] diff_s;

  assign diff_s = bits ^ {ABS_W{polarity}};

  // Highest differing bit wins because the loop runs upward.
  always_comb begin
    count = 5'd31;
    for (int i = 0; i < ABS_W; i++) begin
      count = diff_s[i] ? RUN_W'(ABS_W - 1 - i) : count;
    end
  end

endmodule

// File: rtl/shift_left.sv
// Logical left shift; shift amounts of W or more flush the word to zero.
module shift_left #(
  parameter int W  = 31,
  parameter int SW = 6
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  result
);

  assign result = (amt >= SW'(W)) ? {W{1'b0}} : (data << amt);

endmodule

// File: rtl/posit_decode_pipe_es3.sv
// Three-stage posit<32,3> decoder: classify, regime extraction, field assembly.
// Elastic valid/ready pipeline sustaining one word per cycle.
module posit_decode_pipe_es3
  import posit_defines_es3::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NBITS-1:0]                      in_posit,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] out_value,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  logic              v1_r, v2_r;
  posit_stage1_es3_t s1_r, s1_s;
  posit_stage2_es3_t s2_r, s2_s;
  posit_value_es3_t  value_s;
  logic              ready_out_s, ready2_s, ready1_s;
  logic [RUN_W-1:0]  run_len_s;
  logic [SHAMT_W-1:0] shift_amt_s;
  logic [ABS_W-1:0]  rem_s;

  assign ready_out_s = ~out_valid | out_ready;
  assign ready2_s    = ~v2_r | ready_out_s;
  assign ready1_s    = ~v1_r | ready2_s;
  assign in_ready    = ~reset & ready1_s;

  // Stage 1: special-value classification and magnitude.
  always_comb begin
    s1_s.sgn  = in_posit[NBITS-1];
    s1_s.zero = (in_posit == 32'h0);
    s1_s.inf  = (in_posit == POSIT_NAR);
    if (in_posit[NBITS-1]) begin
      s1_s.abs_val = 31'd0 - in_posit[ABS_W-1:0];
    end else begin
      s1_s.abs_val = in_posit[ABS_W-1:0];
    end
  end

  posit_run_count_es3 u_run_count (
    .bits     (s1_r.abs_val),
    .polarity (s1_r.abs_val[ABS_W-1]),
    .count    (run_len_s)
  );

  // The shift also consumes the regime terminator bit.
  assign shift_amt_s = {1'b0, run_len_s} + 6'd1;

  shift_left #(.W(ABS_W), .SW(SHAMT_W)) u_shift (
    .data   (s1_r.abs_val),
    .amt    (shift_amt_s),
    .result (rem_s)
  );

  // Stage 2: regime value and left-aligned remainder.
  always_comb begin
    s2_s.sgn  = s1_r.sgn;
    s2_s.inf  = s1_r.inf;
    s2_s.zero = s1_r.zero;
    s2_s.rem  = rem_s;
    if (s1_r.abs_val[ABS_W-1]) begin
      s2_s.regime = signed'({1'b0, run_len_s} - 6'd1);
    end else begin
      s2_s.regime = signed'(6'd0 - {1'b0, run_len_s});
    end
  end

  // Stage 3: scale = regime*8 + exp is a plain concatenation since exp < 8.
  always_comb begin
    value_s = '0;
    if (s2_r.zero) begin
      value_s.zero = 1'b1;
    end else if (s2_r.inf) begin
      value_s.inf = 1'b1;
    end else begin
      value_s.sgn      = s2_r.sgn;
      value_s.scale    = {s2_r.regime, s2_r.rem[ABS_W-1:ABS_W-ES]};
      value_s.fraction = s2_r.rem[ABS_W-ES-1:2];
    end
  end

  // Pipeline registers; each stage loads when the stage downstream can take its word.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
      s1_r      <= '0;
      s2_r      <= '0;
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      if (ready1_s) begin
        v1_r <= in_valid;
        s1_r <= s1_s;
      end
      if (ready2_s) begin
        v2_r <= v1_r;
        s2_r <= s2_s;
      end
      if (ready_out_s) begin
        out_valid <= v2_r;
        if (v2_r) begin
          out_value <= value_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_posit_decode_pipe_es3.sv
// Self-checking bench for posit_decode_pipe_es3: directed vectors, backpressure,
// mid-stream reset and a random sweep against an arithmetic decode model.
module tb_posit_decode_pipe_es3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_posit = 32'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [37:0] out_value;
  logic        out_valid;
  logic        out_ready = 1'b0;

  posit_decode_pipe_es3 dut (
    .clk       (clk),
    .reset     (reset),
    .in_posit  (in_posit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_value (out_value),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [37:0] exp;
    logic [31:0] word;
    int          cyc;
  } item_t;

  item_t       q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          lat_check = 1'b0;
  logic        stall_prev = 1'b0;
  logic [37:0] held = 38'h0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decode from the posit definition: sign, magnitude, regime run, exponent, fraction.
  function automatic logic [37:0] model(input logic [31:0] p);
    longint a, tail;
    int k, r0, rg, n, e, sc;
    logic [8:0]  s9;
    logic [25:0] fr;
    if (p == 32'h0) return 38'h1;
    if (p == 32'h8000_0000) return 38'h2;
    a = p[31] ? ((64'h8000_0000 - longint'(p[30:0])) & 64'h7FFF_FFFF) : longint'(p[30:0]);
    r0 = int'((a >> 30) & 64'd1);
    k = 0;
    while (k < 31 && int'((a >> (30 - k)) & 64'd1) == r0) k++;
    rg = (r0 == 1) ? k - 1 : -k;
    n = 30 - k;
    if (n < 0) n = 0;
    tail = (a & ((64'd1 << n) - 64'd1)) << (31 - n);
    e = int'((tail >> 28) & 64'd7);
    fr = 26'((tail >> 2) & 64'h3FF_FFFF);
    sc = rg * 8 + e;
    s9 = 9'(sc);
    return {p[31], s9, fr, 2'b00};
  endfunction

  // Re-encode a record into a posit word as an independent round-trip check.
  function automatic logic [31:0] encode(input logic [37:0] v);
    logic [127:0] s;
    logic [30:0]  mag;
    int len, sc, e, rg;
    if (v[0]) return 32'h0;
    if (v[1]) return 32'h8000_0000;
    sc = int'($signed(v[36:28]));
    e = sc & 7;
    rg = (sc - e) / 8;
    s = 128'h0;
    len = 0;
    if (rg >= 0) begin
      for (int i = 0; i <= rg; i++) begin s = {s[126:0], 1'b1}; len++; end
      s = {s[126:0], 1'b0}; len++;
    end else begin
      for (int i = 0; i < -rg; i++) begin s = {s[126:0], 1'b0}; len++; end
      s = {s[126:0], 1'b1}; len++;
    end
    for (int i = 30; i >= 2; i--) begin s = {s[126:0], v[i]}; len++; end
    mag = 31'(s >> (len - 31));
    return v[37] ? (32'd0 - {1'b0, mag}) : {1'b0, mag};
  endfunction

  // One handshake cycle: drive at negedge, sample 1 time unit later, settle on posedge.
  task automatic cycle(input logic v, input logic [31:0] p, input logic [37:0] e,
                       input logic ordy, output logic acc);
    logic        ox;
    logic [37:0] ov;
    item_t       it;
    @(negedge clk);
    in_valid = v;
    in_posit = p;
    out_ready = ordy;
    #1;
    acc = v & in_ready;
    ox = out_valid & out_ready;
    ov = out_value;
    if (stall_prev) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_value", 64'(out_value), 64'(held));
    end
    stall_prev = out_valid & ~out_ready;
    held = out_value;
    @(posedge clk);
    cyc++;
    if (ox) begin
      check("out_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        it = q.pop_front();
        check("value", 64'(ov), 64'(it.exp));
        check("roundtrip", 64'(encode(ov)), 64'(it.word));
        if (lat_check) check("latency", 64'(cyc - it.cyc), 64'd3);
      end
    end
    if (acc) q.push_back('{e, p, cyc});
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && q.size() > 0; i++) cycle(1'b0, 32'h0, 38'h0, 1'b1, acc);
    check("drained", 64'(q.size()), 64'd0);
  endtask

  logic [31:0] dir_w[4] = '{32'h4000_0000, 32'h4200_0000, 32'hC000_0000, 32'h5000_0000};
  logic [37:0] dir_e[4] = '{38'h00_0000_0000, 38'h00_0800_0000, 38'h20_0000_0000, 38'h00_4000_0000};
  logic [31:0] ext_w[5] = '{32'h0000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0001};
  logic [37:0] ext_e[5] = '{38'h1, 38'h2, 38'h0F_0000_0000, 38'h11_0000_0000, 38'h2F_0000_0000};

  initial begin
    logic        acc;
    logic [31:0] bp_w[8];
    logic [31:0] p;
    int          idx;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_value", 64'(out_value), 64'd0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Directed back-to-back words, with latency checked
    lat_check = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, dir_w[i], dir_e[i], 1'b1, acc);
      check("dir_accept", 64'(acc), 64'd1);
    end
    drain(10);

    // Specials and extremes
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, ext_w[i], ext_e[i], 1'b1, acc);
      check("ext_accept", 64'(acc), 64'd1);
    end
    drain(10);
    lat_check = 1'b0;

    // Backpressure: 8 words offered, output stalled for 5 cycles
    for (int i = 0; i < 8; i++) bp_w[i] = $urandom;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, bp_w[idx], model(bp_w[idx]), 1'b0, acc);
      if (acc) idx++;
    end
    check("bp_accepts", 64'(idx), 64'd3);
    @(negedge clk);
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 50 && idx < 8; i++) begin
      cycle(1'b1, bp_w[idx], model(bp_w[idx]), 1'b1, acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd8);
    drain(20);

    // Reset with three words in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 38'h0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_out_value", 64'(out_value), 64'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 38'h0, 1'b1, acc);
      #1;
      check("post_reset_idle", 64'(out_valid), 64'd0);
    end

    // Random sweep with random valid/ready
    for (int i = 0; i < 10000; i++) begin
      p = $urandom;
      if ($urandom_range(0, 15) == 0) p = ext_w[$urandom_range(0, 4)];
      cycle(1'($urandom_range(0, 3) != 0), p, model(p), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
